// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the alu command sequencer: opcodes, alu
// function codes, FSM states and the multiply step count.
package alu_seq_pkg;

  localparam int DATA_W    = 32;
  localparam int MUL_STEPS = 32;
  localparam int CNT_W     = $clog2(MUL_STEPS);

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_MUL = 3'b011,
    OP_SUB = 3'b110,
    OP_SLT = 3'b111
  } op_t;

  localparam logic [2:0] F_AND = 3'b000;
  localparam logic [2:0] F_OR  = 3'b001;
  localparam logic [2:0] F_ADD = 3'b010;
  localparam logic [2:0] F_SUB = 3'b110;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    MUL,
    DONE
  } state_t;

  // 100 and 101 have no alu meaning and are answered with an error response.
  function automatic logic op_legal(input logic [2:0] op);
    return !(op == 3'b100 || op == 3'b101);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Command and response valid/ready channels between a requester (master)
// and the alu sequencer (slave).
interface alu_seq_if
  import alu_seq_pkg::*;
#(
  parameter int TAG_W = 4
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;
  logic [TAG_W-1:0]  cmd_tag;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_y;
  logic              rsp_zero;
  logic              rsp_carry;
  logic              rsp_err;
  logic [TAG_W-1:0]  rsp_tag;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_y, rsp_zero, rsp_carry, rsp_err, rsp_tag
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag, rsp_ready,
    output cmd_ready, rsp_valid, rsp_y, rsp_zero, rsp_carry, rsp_err, rsp_tag
  );

endinterface

// File: rtl/alu_sequencer_alu.sv
// 32-bit combinational alu: f[2] inverts b and injects carry-in,
// f[1:0] selects AND / OR / sum / set-less-than-sign.
module alu
  import alu_seq_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        f,
  output logic [DATA_W-1:0] y,
  output logic              cout
);

  logic [DATA_W-1:0] b_eff;
  logic [DATA_W-1:0] sum;

  assign b_eff       = f[2] ? ~b : b;
  assign {cout, sum} = {1'b0, a} + {1'b0, b_eff} + (DATA_W+1)'(f[2]);

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned and a latch is never inferred.
  always_comb begin
    y = sum;
    unique case (f[1:0])
      2'b00:   y = a & b_eff;
      2'b01:   y = a | b_eff;
      2'b10:   y = sum;
      default: y = {{(DATA_W-1){1'b0}}, sum[DATA_W-1]};
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Command front end for the alu: registers operands, runs simple ops in one
// cycle and MUL as 32 shift-add steps, then holds the response until taken.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int TAG_W = 4,
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      reset_n,
  alu_seq_if.slave  bus,
  output logic      busy
);

  if (WIDTH != 32) begin : g_width_check
    $error("alu_sequencer: WIDTH must be 32 to match the alu");
  end

  state_t             state, state_next;
  op_t                op_q;
  logic [WIDTH-1:0]   opa, opb, acc;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   y_q;
  logic               zero_q, carry_q, err_q;
  logic [TAG_W-1:0]   tag_q;

  logic [WIDTH-1:0]   alu_a, alu_b, alu_y;
  logic [2:0]         alu_f;
  logic               alu_cout;
  logic               lt;
  logic [WIDTH-1:0]   exec_y, mul_y;
  logic               exec_carry;
  logic               take_cmd;

  assign take_cmd      = (state == IDLE) && bus.cmd_valid;
  assign bus.cmd_ready = (state == IDLE);
  assign bus.rsp_valid = (state == DONE);
  assign busy          = (state != IDLE);
  assign bus.rsp_y     = y_q;
  assign bus.rsp_zero  = zero_q;
  assign bus.rsp_carry = carry_q;
  assign bus.rsp_err   = err_q;
  assign bus.rsp_tag   = tag_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (bus.cmd_valid) begin
        if (!op_legal(bus.cmd_op))          state_next = DONE;
        else if (op_t'(bus.cmd_op) == OP_MUL) state_next = MUL;
        else                                 state_next = EXEC;
      end
      EXEC:    state_next = DONE;
      MUL:     if (cnt == CNT_W'(MUL_STEPS - 1)) state_next = DONE;
      default: if (bus.rsp_ready) state_next = IDLE;
    endcase
  end

  // During MUL the adder accumulates the shifted multiplicand.
  always_comb begin
    alu_a = opa;
    alu_b = opb;
    alu_f = F_ADD;
    if (state == MUL) begin
      alu_a = acc;
      alu_b = opa;
    end else begin
      unique case (op_q)
        OP_AND:         alu_f = F_AND;
        OP_OR:          alu_f = F_OR;
        OP_SUB, OP_SLT: alu_f = F_SUB;
        default:        alu_f = F_ADD;
      endcase
    end
  end

  alu u_alu (
    .a    (alu_a),
    .b    (alu_b),
    .f    (alu_f),
    .y    (alu_y),
    .cout (alu_cout)
  );

  // Signed compare: differing signs decide directly, else the difference sign.
  assign lt         = (opa[WIDTH-1] != opb[WIDTH-1]) ? opa[WIDTH-1] : alu_y[WIDTH-1];
  assign exec_y     = (op_q == OP_SLT) ? {{(WIDTH-1){1'b0}}, lt} : alu_y;
  assign exec_carry = ((op_q == OP_ADD) || (op_q == OP_SUB)) && alu_cout;
  assign mul_y      = opb[0] ? alu_y : acc;

  // NOTE: operand and accumulator registers carry no reset; they are always
  // loaded at the command handshake before anything reads them.
  always_ff @(posedge clk) begin
    if (take_cmd) begin
      op_q <= op_t'(bus.cmd_op);
      opa  <= bus.cmd_a;
      opb  <= bus.cmd_b;
      acc  <= '0;
    end else if (state == MUL) begin
      acc <= mul_y;
      opa <= opa << 1;
      opb <= opb >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      y_q     <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
      tag_q   <= '0;
      cnt     <= '0;
    end else begin
      unique case (state)
        IDLE: if (bus.cmd_valid) begin
          tag_q <= bus.cmd_tag;
          cnt   <= '0;
          if (!op_legal(bus.cmd_op)) begin
            y_q     <= '0;
            zero_q  <= 1'b1;
            carry_q <= 1'b0;
            err_q   <= 1'b1;
          end
        end
        EXEC: begin
          y_q     <= exec_y;
          zero_q  <= (exec_y == '0);
          carry_q <= exec_carry;
          err_q   <= 1'b0;
        end
        MUL: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(MUL_STEPS - 1)) begin
            y_q     <= mul_y;
            zero_q  <= (mul_y == '0);
            carry_q <= 1'b0;
            err_q   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomised and directed bench for alu_sequencer, checked every cycle
// against an arithmetic model of each command's response.
module tb_alu_sequencer;
  import alu_seq_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  logic busy;

  alu_seq_if #(.TAG_W(4)) bus ();

  alu_sequencer #(.TAG_W(4), .WIDTH(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] y;
    logic        zero;
    logic        carry;
    logic        err;
    logic [3:0]  tag;
  } rsp_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  rsp_t exp_rsp;
  bit   exp_pending = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic rsp_t model(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [3:0] tag);
    rsp_t        r;
    logic [32:0] wide;
    r.tag   = tag;
    r.err   = 1'b0;
    r.carry = 1'b0;
    r.y     = 32'd0;
    case (op)
      3'b000: r.y = a & b;
      3'b001: r.y = a | b;
      3'b010: begin
        wide    = {1'b0, a} + {1'b0, b};
        r.y     = wide[31:0];
        r.carry = wide[32];
      end
      3'b110: begin
        r.y     = a - b;
        r.carry = (a >= b);
      end
      3'b111: r.y = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b011: r.y = a * b;
      default: r.err = 1'b1;
    endcase
    r.zero = (r.y == 32'd0);
    return r;
  endfunction

  function automatic int latency(input logic [2:0] op);
    if (op == 3'b100 || op == 3'b101) return 1;
    if (op == 3'b011) return 33;
    return 2;
  endfunction

  // Every cycle a response is presented it must be the one expected.
  always @(negedge clk) begin
    if (reset_n) begin
      check("rsp_valid_vs_pending", 64'(bus.rsp_valid & ~exp_pending), 64'(0));
      if (bus.rsp_valid && exp_pending) begin
        check("rsp_y",     64'(bus.rsp_y),     64'(exp_rsp.y));
        check("rsp_zero",  64'(bus.rsp_zero),  64'(exp_rsp.zero));
        check("rsp_carry", 64'(bus.rsp_carry), 64'(exp_rsp.carry));
        check("rsp_err",   64'(bus.rsp_err),   64'(exp_rsp.err));
        check("rsp_tag",   64'(bus.rsp_tag),   64'(exp_rsp.tag));
        check("cmd_ready_in_done", 64'(bus.cmd_ready), 64'(0));
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] tag, input bit noisy);
    int w = 0;
    @(negedge clk);
    while (!bus.cmd_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!bus.cmd_ready) check("cmd_ready_wait", 64'(bus.cmd_ready), 64'(1));
    exp_rsp       = model(op, a, b, tag);
    exp_pending   = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_tag   = tag;
    @(posedge clk);
    #1;
    bus.cmd_valid = noisy ? 1'($urandom_range(1)) : 1'b0;
    bus.cmd_op    = 3'($urandom);
    bus.cmd_a     = $urandom;
    bus.cmd_b     = $urandom;
    bus.cmd_tag   = 4'($urandom);
  endtask

  task automatic collect(input int exp_lat, input int hold);
    int lat = 1;
    if (hold == 0) bus.rsp_ready = 1'b1;
    while (!bus.rsp_valid && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    bus.cmd_valid = 1'b0;
    check("latency", 64'(lat), 64'(exp_lat));
    if (bus.rsp_valid) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        check("held_rsp_valid", 64'(bus.rsp_valid), 64'(1));
        check("held_cmd_ready", 64'(bus.cmd_ready), 64'(0));
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      check("released_rsp_valid", 64'(bus.rsp_valid), 64'(0));
      check("released_cmd_ready", 64'(bus.cmd_ready), 64'(1));
    end
    exp_pending   = 1'b0;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic do_cmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] tag, input int hold, input bit noisy);
    issue(op, a, b, tag, noisy);
    collect(latency(op), hold);
  endtask

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(4))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000 ^ 32'($urandom_range(3));
      3:       return 32'($urandom_range(20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rsp_t m;
    reset_n       = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'b000;
    bus.cmd_a     = 32'd0;
    bus.cmd_b     = 32'd0;
    bus.cmd_tag   = 4'd0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    check("reset_cmd_ready", 64'(bus.cmd_ready), 64'(1));
    check("reset_busy",      64'(busy),          64'(0));
    check("reset_rsp_y",     64'(bus.rsp_y),     64'(0));
    check("reset_rsp_flags", 64'({bus.rsp_zero, bus.rsp_carry, bus.rsp_err}), 64'(0));
    check("reset_rsp_tag",   64'(bus.rsp_tag),   64'(0));
    reset_n = 1'b1;

    // Pin the model to hand-computed results.
    m = model(3'b010, 32'hFFFF_FFFF, 32'h1, 4'd3);
    check("pin_add", 64'(m), 64'({32'h0, 1'b1, 1'b1, 1'b0, 4'd3}));
    m = model(3'b110, 32'd5, 32'd7, 4'd0);
    check("pin_sub", 64'(m), 64'({32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 4'd0}));
    m = model(3'b111, 32'h8000_0000, 32'd1, 4'd0);
    check("pin_slt_neg", 64'(m.y), 64'(1));
    m = model(3'b111, 32'd1, 32'h8000_0000, 4'd0);
    check("pin_slt_pos", 64'(m.y), 64'(0));
    m = model(3'b011, 32'h0001_0003, 32'd5, 4'd0);
    check("pin_mul", 64'(m.y), 64'(32'h0005_000F));
    m = model(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd0);
    check("pin_mul_wrap", 64'(m.y), 64'(1));
    m = model(3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd0);
    check("pin_and", 64'(m.y), 64'(32'hF000_F000));
    m = model(3'b101, 32'd9, 32'd9, 4'd0);
    check("pin_illegal", 64'({m.y, m.zero, m.err}), 64'({32'h0, 1'b1, 1'b1}));

    do_cmd(3'b010, 32'hFFFF_FFFF, 32'h1, 4'd3, 0, 1'b0);
    do_cmd(3'b110, 32'd5, 32'd7, 4'd1, 0, 1'b0);
    do_cmd(3'b111, 32'h8000_0000, 32'd1, 4'd2, 1, 1'b0);
    do_cmd(3'b111, 32'd1, 32'h8000_0000, 4'd4, 0, 1'b1);
    do_cmd(3'b011, 32'h0001_0003, 32'd5, 4'd5, 0, 1'b0);
    do_cmd(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd6, 2, 1'b1);
    do_cmd(3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd7, 10, 1'b1);
    do_cmd(3'b101, 32'd9, 32'd9, 4'd8, 0, 1'b0);
    do_cmd(3'b001, 32'h1234_0000, 32'h0000_5678, 4'd9, 0, 1'b0);

    // Reset in the middle of a multiply abandons it without a response.
    issue(3'b011, 32'd12345, 32'd6789, 4'd10, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset_n     = 1'b0;
    exp_pending = 1'b0;
    @(posedge clk);
    #1;
    check("mid_reset_busy",      64'(busy),          64'(0));
    check("mid_reset_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    check("mid_reset_cmd_ready", 64'(bus.cmd_ready), 64'(1));
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    do_cmd(3'b010, 32'd2, 32'd2, 4'd11, 0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      logic [2:0] op;
      op = 3'($urandom);
      do_cmd(op, rand_opnd(), rand_opnd(), 4'($urandom), $urandom_range(3), 1'($urandom_range(1)));
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
